// File: rtl/stack_writer.sv
// Memory write sequencer for stores and 1/2/3-byte stack pushes.
// Emits one registered byte per clock and reports the updated stack pointer on the last write.
module stack_writer #(
    parameter int                    REG_WIDTH  = 8,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] STACK_BASE = 16'h0100
) (
    input  logic                  phi1,
    input  logic                  reset,
    input  logic                  req,
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [REG_WIDTH-1:0]  data_in,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic [REG_WIDTH-1:0]  sp_in,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [REG_WIDTH-1:0]  data_out,
    output logic                  wr_en,
    output logic [REG_WIDTH-1:0]  sp_out,
    output logic                  sp_we
);

    typedef enum logic [1:0] {IDLE, WR0, WR1, WR2} state_t;
    typedef enum logic [1:0] {M_STORE, M_PUSH1, M_PUSH2, M_PUSH3} mode_t;

    state_t                r_state;
    state_t                w_state_next;
    mode_t                 r_mode;
    logic [ADDR_WIDTH-1:0] r_addr_l;
    logic [ADDR_WIDTH-1:0] r_pc_l;
    logic [REG_WIDTH-1:0]  r_data_l;
    logic [REG_WIDTH-1:0]  r_sp_l;

    logic [1:0]            w_last_idx;
    logic                  w_last;
    logic                  w_accept;

    mode_t                 w_src_mode;
    logic [ADDR_WIDTH-1:0] w_src_addr;
    logic [ADDR_WIDTH-1:0] w_src_pc;
    logic [REG_WIDTH-1:0]  w_src_data;
    logic [REG_WIDTH-1:0]  w_src_sp;
    logic [1:0]            w_src_last_idx;
    logic [1:0]            w_k;

    logic                  w_busy_n;
    logic                  w_done_n;
    logic                  w_wr_en_n;
    logic                  w_sp_we_n;
    logic [ADDR_WIDTH-1:0] w_addr_n;
    logic [REG_WIDTH-1:0]  w_data_n;
    logic [REG_WIDTH-1:0]  w_sp_out_n;

    assign w_last_idx = (r_mode == M_STORE) ? 2'd0 : 2'(r_mode) - 2'd1;
    assign w_last     = ((r_state == WR0) && (w_last_idx == 2'd0)) ||
                        ((r_state == WR1) && (w_last_idx == 2'd1)) ||
                         (r_state == WR2);
    // A request on the final byte's edge starts the next transaction with no idle cycle.
    assign w_accept   = req && ((r_state == IDLE) || w_last);

    always_ff @(posedge phi1 or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = WR0;
        end else if ((r_state == IDLE) || w_last) begin
            w_state_next = IDLE;
        end else begin
            unique case (r_state)
                WR0:     w_state_next = WR1;
                WR1:     w_state_next = WR2;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Outputs are computed for the state being entered, then registered.
    always_comb begin
        w_src_mode     = w_accept ? mode_t'(mode) : r_mode;
        w_src_addr     = w_accept ? addr_in : r_addr_l;
        w_src_pc       = w_accept ? pc_in   : r_pc_l;
        w_src_data     = w_accept ? data_in : r_data_l;
        w_src_sp       = w_accept ? sp_in   : r_sp_l;
        w_src_last_idx = (w_src_mode == M_STORE) ? 2'd0 : 2'(w_src_mode) - 2'd1;
        w_k            = 2'd0;
        w_busy_n       = 1'b0;
        w_done_n       = 1'b0;
        w_wr_en_n      = 1'b0;
        w_sp_we_n      = 1'b0;
        w_addr_n       = '0;
        w_data_n       = '0;
        w_sp_out_n     = sp_out;
        if (w_state_next != IDLE) begin
            w_busy_n  = 1'b1;
            w_wr_en_n = 1'b1;
            unique case (w_state_next)
                WR0: begin
                    w_k = 2'd0;
                    if (w_src_mode == M_STORE) begin
                        w_addr_n = w_src_addr;
                    end else begin
                        w_addr_n = {STACK_BASE[ADDR_WIDTH-1:REG_WIDTH], w_src_sp};
                    end
                    if ((w_src_mode == M_STORE) || (w_src_mode == M_PUSH1)) begin
                        w_data_n = w_src_data;
                    end else begin
                        w_data_n = w_src_pc[ADDR_WIDTH-1 -: REG_WIDTH];
                    end
                end
                WR1: begin
                    w_k      = 2'd1;
                    w_addr_n = {STACK_BASE[ADDR_WIDTH-1:REG_WIDTH], w_src_sp - REG_WIDTH'(1)};
                    w_data_n = w_src_pc[REG_WIDTH-1:0];
                end
                default: begin
                    w_k      = 2'd2;
                    w_addr_n = {STACK_BASE[ADDR_WIDTH-1:REG_WIDTH], w_src_sp - REG_WIDTH'(2)};
                    w_data_n = w_src_data;
                end
            endcase
            if (w_k == w_src_last_idx) begin
                w_done_n = 1'b1;
                if (w_src_mode == M_STORE) begin
                    w_sp_out_n = w_src_sp;
                end else begin
                    w_sp_out_n = w_src_sp - (REG_WIDTH'(w_src_last_idx) + REG_WIDTH'(1));
                    w_sp_we_n  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge phi1 or posedge reset) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_en    <= 1'b0;
            sp_we    <= 1'b0;
            addr     <= '0;
            data_out <= '0;
            sp_out   <= '1;
            r_mode   <= M_STORE;
            r_addr_l <= '0;
            r_pc_l   <= '0;
            r_data_l <= '0;
            r_sp_l   <= '0;
        end else begin
            busy     <= w_busy_n;
            done     <= w_done_n;
            wr_en    <= w_wr_en_n;
            sp_we    <= w_sp_we_n;
            addr     <= w_addr_n;
            data_out <= w_data_n;
            sp_out   <= w_sp_out_n;
            if (w_accept) begin
                r_mode   <= mode_t'(mode);
                r_addr_l <= addr_in;
                r_pc_l   <= pc_in;
                r_data_l <= data_in;
                r_sp_l   <= sp_in;
            end
        end
    end

endmodule

// File: tb/tb_stack_writer.sv
// Directed bench for stack_writer: stores, pushes, SP wrap, back-to-back, busy-ignore, mid-push reset.
module tb_stack_writer;

    logic        phi1 = 1'b0;
    logic        reset;
    logic        req;
    logic [1:0]  mode;
    logic [15:0] addr_in;
    logic [7:0]  data_in;
    logic [15:0] pc_in;
    logic [7:0]  sp_in;
    logic        busy;
    logic        done;
    logic [15:0] addr;
    logic [7:0]  data_out;
    logic        wr_en;
    logic [7:0]  sp_out;
    logic        sp_we;

    int n_checks = 0;
    int n_err    = 0;

    stack_writer #(
        .REG_WIDTH (8),
        .ADDR_WIDTH(16),
        .STACK_BASE(16'h0100)
    ) dut (
        .phi1    (phi1),
        .reset   (reset),
        .req     (req),
        .mode    (mode),
        .addr_in (addr_in),
        .data_in (data_in),
        .pc_in   (pc_in),
        .sp_in   (sp_in),
        .busy    (busy),
        .done    (done),
        .addr    (addr),
        .data_out(data_out),
        .wr_en   (wr_en),
        .sp_out  (sp_out),
        .sp_we   (sp_we)
    );

    always #5 phi1 = ~phi1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge phi1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic e_busy, input logic e_done,
                           input logic e_wr, input logic e_spwe, input logic [15:0] e_addr,
                           input logic [7:0] e_data, input logic [7:0] e_sp);
        chk({tag, ".busy"},  32'(busy),     32'(e_busy));
        chk({tag, ".done"},  32'(done),     32'(e_done));
        chk({tag, ".wr_en"}, 32'(wr_en),    32'(e_wr));
        chk({tag, ".sp_we"}, 32'(sp_we),    32'(e_spwe));
        chk({tag, ".addr"},  32'(addr),     32'(e_addr));
        chk({tag, ".data"},  32'(data_out), 32'(e_data));
        chk({tag, ".sp"},    32'(sp_out),   32'(e_sp));
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; mode = 2'd0;
        addr_in = 16'h0; data_in = 8'h0; pc_in = 16'h0; sp_in = 8'h0;
        tick();
        tick();
        chk_bus("reset", 0, 0, 0, 0, 16'h0000, 8'h00, 8'hFF);
        reset = 1'b0;
        tick();
        chk_bus("idle0", 0, 0, 0, 0, 16'h0000, 8'h00, 8'hFF);

        // STORE
        mode = 2'd0; addr_in = 16'h0200; data_in = 8'h5A; sp_in = 8'hFD; req = 1'b1;
        tick();
        req = 1'b0; mode = 2'd3; addr_in = 16'hFFFF; data_in = 8'h00; sp_in = 8'h11;
        chk_bus("store.b0", 1, 1, 1, 0, 16'h0200, 8'h5A, 8'hFD);
        tick();
        chk_bus("store.idle", 0, 0, 0, 0, 16'h0000, 8'h00, 8'hFD);

        // PUSH2 (JSR)
        mode = 2'd2; pc_in = 16'hC012; sp_in = 8'hFD; req = 1'b1;
        tick();
        req = 1'b0; mode = 2'd0; pc_in = 16'h0000; sp_in = 8'h00;
        chk_bus("push2.b0", 1, 0, 1, 0, 16'h01FD, 8'hC0, 8'hFD);
        tick();
        chk_bus("push2.b1", 1, 1, 1, 1, 16'h01FC, 8'h12, 8'hFB);
        tick();
        chk_bus("push2.idle", 0, 0, 0, 0, 16'h0000, 8'h00, 8'hFB);

        // PUSH3 with SP wrap
        mode = 2'd3; pc_in = 16'h8003; data_in = 8'h34; sp_in = 8'h01; req = 1'b1;
        tick();
        req = 1'b0; data_in = 8'hEE; sp_in = 8'h77;
        chk_bus("push3.b0", 1, 0, 1, 0, 16'h0101, 8'h80, 8'hFB);
        tick();
        chk_bus("push3.b1", 1, 0, 1, 0, 16'h0100, 8'h03, 8'hFB);
        tick();
        chk_bus("push3.b2", 1, 1, 1, 1, 16'h01FF, 8'h34, 8'hFE);
        tick();
        chk_bus("push3.idle", 0, 0, 0, 0, 16'h0000, 8'h00, 8'hFE);

        // Back-to-back PUSH1 with req held
        mode = 2'd1; data_in = 8'hAA; sp_in = 8'hFF; req = 1'b1;
        tick();
        chk_bus("b2b.t0", 1, 1, 1, 1, 16'h01FF, 8'hAA, 8'hFE);
        tick();
        chk_bus("b2b.t1", 1, 1, 1, 1, 16'h01FF, 8'hAA, 8'hFE);

        // Still holding req: PUSH2 accepted back-to-back, then a STORE req while busy is dropped
        mode = 2'd2; pc_in = 16'h1234; sp_in = 8'h80;
        tick();
        chk_bus("ign.b0", 1, 0, 1, 0, 16'h0180, 8'h12, 8'hFE);
        mode = 2'd0; addr_in = 16'h0300; data_in = 8'h77; sp_in = 8'h10;
        tick();
        chk_bus("ign.b1", 1, 1, 1, 1, 16'h017F, 8'h34, 8'h7E);
        req = 1'b0;
        tick();
        chk_bus("ign.idle", 0, 0, 0, 0, 16'h0000, 8'h00, 8'h7E);

        // Reset between byte 0 and byte 1 of a PUSH3
        mode = 2'd3; pc_in = 16'hABCD; data_in = 8'h11; sp_in = 8'h50; req = 1'b1;
        tick();
        req = 1'b0;
        chk_bus("rst.b0", 1, 0, 1, 0, 16'h0150, 8'hAB, 8'h7E);
        #2;
        reset = 1'b1;
        #1;
        chk_bus("rst.async", 0, 0, 0, 0, 16'h0000, 8'h00, 8'hFF);
        tick();
        chk_bus("rst.hold", 0, 0, 0, 0, 16'h0000, 8'h00, 8'hFF);
        reset = 1'b0;
        tick();
        chk_bus("rst.after", 0, 0, 0, 0, 16'h0000, 8'h00, 8'hFF);
        tick();
        chk_bus("rst.after2", 0, 0, 0, 0, 16'h0000, 8'h00, 8'hFF);

        // Fresh PUSH1 after reset
        mode = 2'd1; data_in = 8'h5C; sp_in = 8'h20; req = 1'b1;
        tick();
        req = 1'b0;
        chk_bus("post.b0", 1, 1, 1, 1, 16'h0120, 8'h5C, 8'h1F);
        tick();
        chk_bus("post.idle", 0, 0, 0, 0, 16'h0000, 8'h00, 8'h1F);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
